wordline_sequencer: RTL and testbench

//   Parametrised, clocked row decoder and word-line sequencer for the NAND-latch bitcell array.

---
 rtl/wordline_sequencer.sv | 96 +++++++++
 tb/tb_wordline_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wordline_sequencer.sv
// Row decoder and word-line sequencer: precharge, then a one-hot word-line pulse,
// then a one-cycle done pulse for each accepted access.
module wordline_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_we,
  output logic                   precharge,
  output logic [(2**ADDR_W)-1:0] sel_x,
  output logic                   we_out,
  output logic                   busy,
  output logic                   done
);

  localparam int ROWS    = 2 ** ADDR_W;
  localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, PRECH, ACT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                precharge_q, precharge_d;
  logic [ROWS-1:0]     sel_x_q, sel_x_d;
  logic                we_out_q, we_out_d;
  logic                done_q, done_d;
  logic                accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      precharge_q <= 1'b0;
      sel_x_q     <= '0;
      we_out_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      precharge_q <= precharge_d;
      sel_x_q     <= sel_x_d;
      we_out_q    <= we_out_d;
      done_q      <= done_d;
    end
  end

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = PRECH;
        addr_d  = req_addr;
        we_d    = req_we;
      end
      PRECH: if (cnt_q == CNT_W'(PRE_CYC - 1)) state_d = ACT;
      ACT:   if (cnt_q == CNT_W'(WL_CYC - 1))  state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Phase counter restarts on every state change and rests at zero in IDLE.
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    precharge_d = (state_d == PRECH);
    sel_x_d     = (state_d == ACT) ? (ROWS'(1) << addr_d) : '0;
    we_out_d    = (state_d == ACT) ? we_d : 1'b0;
    done_d      = (state_d == DONE);
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign precharge = precharge_q;
  assign sel_x     = sel_x_q;
  assign we_out    = we_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wordline_sequencer.sv
// Directed bench for wordline_sequencer: default instance plus an
// ADDR_W=4 / PRE_CYC=3 / WL_CYC=1 instance, checked cycle by cycle.
module tb_wordline_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid_a, req_ready_a, req_we_a, precharge_a, we_out_a, busy_a, done_a;
  logic [2:0]  req_addr_a;
  logic [7:0]  sel_x_a;

  logic        req_valid_b, req_ready_b, req_we_b, precharge_b, we_out_b, busy_b, done_b;
  logic [3:0]  req_addr_b;
  logic [15:0] sel_x_b;

  int tests_run = 0;
  int failures  = 0;

  localparam logic [20:0] IDLE_PAT = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

  wordline_sequencer dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a), .req_we(req_we_a),
    .precharge(precharge_a), .sel_x(sel_x_a), .we_out(we_out_a), .busy(busy_a), .done(done_a)
  );

  wordline_sequencer #(.ADDR_W(4), .PRE_CYC(3), .WL_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b), .req_we(req_we_b),
    .precharge(precharge_b), .sel_x(sel_x_b), .we_out(we_out_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {precharge, busy, ready, done, we_out, sel_x[15:0]}.
  function automatic logic [20:0] obs(input int which);
    if (which == 0) return {precharge_a, busy_a, req_ready_a, done_a, we_out_a, 8'h00, sel_x_a};
    return {precharge_b, busy_b, req_ready_b, done_b, we_out_b, sel_x_b};
  endfunction

  task automatic checkOutput(input string tag, input logic [20:0] got, input logic [20:0] want);
    tests_run++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input int which, input int addr, input bit we);
    if (which == 0) begin
      req_valid_a = 1'b1; req_addr_a = 3'(addr); req_we_a = we;
    end else begin
      req_valid_b = 1'b1; req_addr_b = 4'(addr); req_we_b = we;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Walks cycles 1..PRE+WL+2 after the accept edge, checking every output against
  // the expected timeline. Optionally keeps req_valid high, or pulses a stray
  // addr=2 request on instance A during cycles noise_lo..noise_hi.
  task automatic runAccess(input int which, input int addr, input bit we, input bit hold,
                           input int noise_lo, input int noise_hi);
    int pre, wl, n;
    logic [20:0] exp_v, got_v;
    logic [15:0] row;
    bit pre_e, sel_on, busy_e;
    pre = (which == 0) ? 1 : 3;
    wl  = (which == 0) ? 2 : 1;
    n   = pre + wl + 2;
    row = 16'(1) << addr;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        if (which == 0) req_valid_a = 1'b0; else req_valid_b = 1'b0;
      end
      if (noise_lo > 0) begin
        req_valid_a = (c >= noise_lo) && (c <= noise_hi);
        if (req_valid_a) req_addr_a = 3'd2;
      end
      pre_e  = (c >= 1) && (c <= pre);
      sel_on = (c >= pre + 1) && (c <= pre + wl);
      busy_e = (c <= pre + wl + 1);
      exp_v  = {pre_e, busy_e, ~busy_e, (c == pre + wl + 1), sel_on & we, sel_on ? row : 16'h0};
      got_v  = obs(which);
      checkOutput($sformatf("dut%0d addr%0d cyc%0d", which, addr, c), got_v, exp_v);
      checkOutput($sformatf("onehot addr%0d cyc%0d", addr, c), 21'($countones(got_v[15:0]) <= 1), 21'd1);
      checkOutput($sformatf("pre_sel_overlap addr%0d cyc%0d", addr, c), 21'(got_v[20] && (|got_v[15:0])), 21'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_a = 1'b0; req_addr_a = '0; req_we_a = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; req_we_b = 1'b0;
    idleCycles(2);
    checkOutput("reset_a", obs(0), IDLE_PAT);
    checkOutput("reset_b", obs(1), IDLE_PAT);
    rst_n = 1'b1;

    // Default timing: addr 6 write.
    idleCycles(1);
    applyStimulus(0, 6, 1'b1);
    runAccess(0, 6, 1'b1, 1'b0, 0, 0);

    // Every row once, alternating read/write.
    for (int a = 0; a < 8; a++) begin
      idleCycles(1);
      applyStimulus(0, a, (a % 2) == 1);
      runAccess(0, a, (a % 2) == 1, 1'b0, 0, 0);
    end

    // Stray request while busy must be dropped.
    idleCycles(1);
    applyStimulus(0, 3, 1'b0);
    runAccess(0, 3, 1'b0, 1'b0, 1, 3);
    idleCycles(1);
    checkOutput("busy_ignored_idle", obs(0), IDLE_PAT);

    // Back-to-back with req_valid held: second accept at the ready cycle.
    idleCycles(1);
    applyStimulus(0, 1, 1'b0);
    runAccess(0, 1, 1'b0, 1'b1, 0, 0);
    applyStimulus(0, 4, 1'b1);
    runAccess(0, 4, 1'b1, 1'b0, 0, 0);

    // Non-default parameters, top row.
    idleCycles(1);
    applyStimulus(1, 15, 1'b1);
    runAccess(1, 15, 1'b1, 1'b0, 0, 0);

    // Reset in the middle of ACT abandons the access.
    idleCycles(1);
    applyStimulus(0, 5, 1'b0);
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_act", obs(0), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020});
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", obs(0), IDLE_PAT);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset cyc%0d", i), obs(0), IDLE_PAT);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
